i2si_bist_ctrl: RTL
===================

// Module: i2si_bist_ctrl
// PURPOSE
//  Sequencer/checker for the I2S-in saw-tooth BIST generator. Latches rf_bist_* config, holds generator in reset,
//  releases it, gates its sck_transition feed, counts transfers and checks returned data against an internal model.
//  Sits between the register file and the BIST generator/loopback path; reports busy/done/pass/error count back to RF.
// PARAMETERS
//  DATA_W   32  width of checked sample word
//  CNT_W    16  width of sample and error counters
//  TMO_LIM  64  sck_transitions allowed between xfc pulses (only with I2SI_BIST_TIMEOUT_EN)
// PORTS
//  clk                 in   1       master clock (single clock domain)
//  rst                 in   1       synchronous, active-high reset
//  sck_transition      in   1       serial-clock edge pulse
//  rf_bist_en          in   1       level; rising edge starts a run, low aborts or clears
//  rf_bist_start_val   in   12      saw-tooth start value
//  rf_bist_inc         in   8       saw-tooth increment
//  rf_bist_up_limit    in   12      saw-tooth upper limit
//  rf_bist_num_samples in   CNT_W   samples to check per run
//  gen_rst_n           out  1       generator reset, active low
//  gen_sck_transition  out  1       gated sck_transition to generator
//  gen_start_val/gen_inc/gen_up_limit out 12/8/12  latched config to generator
//  bist_xfc            in   1       generator transfer-complete pulse
//  bist_data           in   DATA_W  sample returned from the generator/loopback
//  bist_busy           out  1       run in progress (ARM/RUN)
//  bist_done           out  1       run finished; held until rf_bist_en low
//  bist_pass           out  1       valid while bist_done: err_cnt==0, no cfg_err, no timeout
//  bist_cfg_err        out  1       invalid config detected in ARM
//  bist_timeout        out  1       watchdog fired (0 without macro)
//  bist_err_cnt        out  CNT_W   mismatch count, saturating at all-ones
// BEHAVIOUR
//  Reset: state IDLE; gen_rst_n=0; gen_sck_transition=0; gen_* config=0; all status outputs 0; counters 0.
//  FSM IDLE->ARM->RUN->DONE->IDLE.
//  IDLE: gen_rst_n=0, sck gated. Rising edge of rf_bist_en (registered edge detect) -> ARM; clears err_cnt, sample cnt,
//   cfg_err, timeout, pass, expected model.
//  ARM (1 cycle): latch gen_* from rf_*; busy=1. If rf_bist_inc==0 or start_val>up_limit -> DONE with cfg_err=1.
//   Else if num_samples==0 -> DONE with pass=1. Else -> RUN; gen_rst_n=1 from the RUN entry cycle.
//  RUN: gen_sck_transition = sck_transition (combinational gate, zero latency). On bist_xfc: compare bist_data with
//   exp (zero-extended 12b model); mismatch -> err_cnt+1 (saturating) next cycle; sample_cnt+1; advance model.
//   Model: first exp=start_val; next = (exp>=up_limit) ? start_val : exp+inc (13b add, no wrap for 12b+8b).
//   When sample_cnt reaches num_samples (including the xfc that hits it) -> DONE the following cycle.
//  DONE: sck gated; gen_rst_n=1 (generator idles); done=1; pass computed once on entry.
//   rf_bist_en low -> IDLE; done/pass cleared, err_cnt retained until the next start.
//  Abort: rf_bist_en low in ARM/RUN -> IDLE next cycle; done stays 0; busy drops.
//  Simultaneous xfc and abort: abort wins, sample is not counted. rst mid-run -> reset values next edge.
//  gen_* config is frozen in RUN/DONE; rf_* changes during a run are ignored.
// CONFIGURATION
//  I2SI_BIST_TIMEOUT_EN defined: RUN counts sck_transitions since the last xfc (or since RUN entry); reaching TMO_LIM
//   -> DONE with bist_timeout=1, pass=0. Counter clears on each xfc.
//  Undefined: no watchdog logic; bist_timeout tied 0; a stalled generator leaves the FSM in RUN until abort.
// STRUCTURE
//  Package i2si_bist_pkg: state encoding (IDLE/ARM/RUN/DONE localparams), default TMO_LIM, config-check width constants.
//  One sub-module: i2si_bist_model (expected-value saw-tooth; load/advance inputs; exp output).
// TESTING
//  start=10,inc=5,limit=30,n=8, clean loopback -> exp 10,15,20,25,30,10,15,20; done=1, pass=1, err_cnt=0.
//  Same config, corrupt samples 3 and 6 -> err_cnt=2, pass=0, done=1 after the 8th xfc.
//  inc=0 or start=40,limit=30 -> cfg_err=1, done=1 two cycles after the en edge, gen_rst_n never released.
//  n=0 -> done=1, pass=1, no gen_sck_transition pulses.
//  Deassert rf_bist_en after 3 xfc -> IDLE next cycle, done=0, gen_rst_n=0; re-enable restarts at start_val.
//  With I2SI_BIST_TIMEOUT_EN: stop bist_xfc after the 2nd sample -> timeout=1 after 64 sck_transitions; pass=0.

Source files
------------

// File: rtl/i2si_bist_ctrl_pkg.sv
// Shared constants for the I2S-in BIST sequencer: FSM encoding, config widths, watchdog default.
package i2si_bist_pkg;

    localparam int unsigned CFG_W       = 12;             // start value / upper limit width
    localparam int unsigned INC_W       = 8;              // increment width
    localparam int unsigned SUM_W       = CFG_W + 1;      // model width, holds limit-1 + max inc without wrap
    localparam int unsigned TMO_LIM_DEF = 64;             // default watchdog limit in sck_transitions
    localparam int unsigned ST_W        = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_ARM  = 2'd1;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/i2si_bist_ctrl_if.sv
// Control/data bundle between the BIST sequencer (master) and the saw-tooth generator/loopback (slave).
interface i2si_bist_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    import i2si_bist_pkg::*;

    logic              gen_rst_n;
    logic              gen_sck_transition;
    logic [CFG_W-1:0]  gen_start_val;
    logic [INC_W-1:0]  gen_inc;
    logic [CFG_W-1:0]  gen_up_limit;
    logic              bist_xfc;
    logic [DATA_W-1:0] bist_data;

    modport master (
        output gen_rst_n, gen_sck_transition, gen_start_val, gen_inc, gen_up_limit,
        input  bist_xfc, bist_data
    );

    modport slave (
        input  gen_rst_n, gen_sck_transition, gen_start_val, gen_inc, gen_up_limit,
        output bist_xfc, bist_data
    );

endinterface

// File: rtl/i2si_bist_ctrl_model.sv
// Expected-value saw-tooth: load to start, then step by inc and fold back to start once at/above limit.
module i2si_bist_model
    import i2si_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CFG_W-1:0] load_val,
    input  logic             adv,
    input  logic [CFG_W-1:0] start_val,
    input  logic [INC_W-1:0] inc,
    input  logic [CFG_W-1:0] up_limit,
    output logic [SUM_W-1:0] exp_val
);

    logic [SUM_W-1:0] exp_q;
    logic [SUM_W-1:0] sum;

    assign sum     = exp_q + SUM_W'(inc);
    assign exp_val = exp_q;

    // Model register: load wins over advance
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
        end else if (load) begin
            exp_q <= SUM_W'(load_val);
        end else if (adv) begin
            exp_q <= (exp_q >= SUM_W'(up_limit)) ? SUM_W'(start_val) : sum;
        end
    end

endmodule

// File: rtl/i2si_bist_ctrl.sv
// I2S-in BIST sequencer/checker: arms the saw-tooth generator, gates its sck feed, checks returned samples.
// Optional watchdog on a stalled generator: define I2SI_BIST_TIMEOUT_EN.
module i2si_bist_ctrl
    import i2si_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
`ifdef I2SI_BIST_TIMEOUT_EN
    ,
    parameter int unsigned TMO_LIM = TMO_LIM_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck_transition,
    input  logic             rf_bist_en,
    input  logic [CFG_W-1:0] rf_bist_start_val,
    input  logic [INC_W-1:0] rf_bist_inc,
    input  logic [CFG_W-1:0] rf_bist_up_limit,
    input  logic [CNT_W-1:0] rf_bist_num_samples,
    i2si_bist_ctrl_if.master gen_if,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic             bist_cfg_err,
    output logic             bist_timeout,
    output logic [CNT_W-1:0] bist_err_cnt
);

    logic [ST_W-1:0]  state_q, state_d;
    logic             en_q, en_rise_q;
    logic             gen_rst_n_q, gen_rst_n_d;
    logic [CFG_W-1:0] start_q, start_d, limit_q, limit_d;
    logic [INC_W-1:0] inc_q, inc_d;
    logic [CNT_W-1:0] num_q, num_d, cnt_q, cnt_d, err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, cfg_err_q, cfg_err_d;
    logic             model_load, model_adv;
    logic [SUM_W-1:0] exp_val;
    logic             mismatch;

`ifdef I2SI_BIST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_LIM + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;
    assign bist_timeout = timeout_q;
`else
    assign bist_timeout = 1'b0;
`endif

    i2si_bist_model u_model (
        .clk       (clk),
        .rst       (rst),
        .load      (model_load),
        .load_val  (rf_bist_start_val),
        .adv       (model_adv),
        .start_val (start_q),
        .inc       (inc_q),
        .up_limit  (limit_q),
        .exp_val   (exp_val)
    );

    assign mismatch = gen_if.bist_data != DATA_W'(exp_val);

    // Generator sck feed passes through only while running
    assign gen_if.gen_sck_transition = (state_q == ST_RUN) && sck_transition;
    assign gen_if.gen_rst_n          = gen_rst_n_q;
    assign gen_if.gen_start_val      = start_q;
    assign gen_if.gen_inc            = inc_q;
    assign gen_if.gen_up_limit       = limit_q;

    assign bist_busy    = busy_q;
    assign bist_done    = done_q;
    assign bist_pass    = pass_q;
    assign bist_cfg_err = cfg_err_q;
    assign bist_err_cnt = err_q;

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        gen_rst_n_d = gen_rst_n_q;
        start_d     = start_q;
        inc_d       = inc_q;
        limit_d     = limit_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        done_d      = done_q;
        pass_d      = pass_q;
        cfg_err_d   = cfg_err_q;
        model_load  = 1'b0;
        model_adv   = 1'b0;
`ifdef I2SI_BIST_TIMEOUT_EN
        tmo_d       = tmo_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gen_rst_n_d = 1'b0;
                done_d      = 1'b0;
                pass_d      = 1'b0;
                if (en_rise_q) begin
                    state_d   = ST_ARM;
                    cnt_d     = '0;
                    err_d     = '0;
                    cfg_err_d = 1'b0;
`ifdef I2SI_BIST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_ARM: begin
                start_d    = rf_bist_start_val;
                inc_d      = rf_bist_inc;
                limit_d    = rf_bist_up_limit;
                num_d      = rf_bist_num_samples;
                model_load = 1'b1;
`ifdef I2SI_BIST_TIMEOUT_EN
                tmo_d      = '0;
`endif
                if (!rf_bist_en) begin
                    state_d = ST_IDLE;
                end else if ((rf_bist_inc == '0) || (rf_bist_start_val > rf_bist_up_limit)) begin
                    state_d   = ST_DONE;
                    cfg_err_d = 1'b1;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                end else if (rf_bist_num_samples == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                    gen_rst_n_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!rf_bist_en) begin
                    state_d     = ST_IDLE;
                    gen_rst_n_d = 1'b0;
                end else if (gen_if.bist_xfc) begin
                    model_adv = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (mismatch && (err_q != {CNT_W{1'b1}})) begin
                        err_d = err_q + CNT_W'(1);
                    end
`ifdef I2SI_BIST_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (cnt_d == num_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
`ifdef I2SI_BIST_TIMEOUT_EN
                else if (sck_transition) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_W'(TMO_LIM)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
`endif
            end
            default: begin
                if (!rf_bist_en) begin
                    state_d     = ST_IDLE;
                    gen_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
        endcase
        busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            en_rise_q   <= 1'b0;
            gen_rst_n_q <= 1'b0;
            start_q     <= '0;
            inc_q       <= '0;
            limit_q     <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef I2SI_BIST_TIMEOUT_EN
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            en_q        <= rf_bist_en;
            en_rise_q   <= rf_bist_en && !en_q;
            gen_rst_n_q <= gen_rst_n_d;
            start_q     <= start_d;
            inc_q       <= inc_d;
            limit_q     <= limit_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            cfg_err_q   <= cfg_err_d;
`ifdef I2SI_BIST_TIMEOUT_EN
            tmo_q       <= tmo_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

endmodule
